// File: rtl/crc8_checker_pkg.sv
// Shared CRC-8 definitions for the serial generator and checker: polynomial,
// init value, the framing state type and the single-bit CRC step.
package crc_pkg;

    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // One MSB-first step of the CRC register for a single incoming bit.
    function automatic logic [7:0] crc8_bit(input logic [7:0] crc,
                                            input logic       dataBit,
                                            input logic [7:0] poly);
        logic fb;
        fb = crc[7] ^ dataBit;
        return {crc[6:0], 1'b0} ^ (fb ? poly : 8'h00);
    endfunction

endpackage

// File: rtl/crc8_checker_if.sv
// Byte-stream and frame-result bundle between the UART receiver, the CRC-8
// checker and the frame consumer.
interface crc8_checker_if #(
    parameter int LEN_W = 16
);
    logic             i_valid;
    logic [7:0]       i_data;
    logic             i_sop;
    logic             i_eop;
    logic             o_ready;
    logic             o_done;
    logic             o_pass;
    logic             o_err_len;
    logic [7:0]       o_residue;
    logic [LEN_W-1:0] o_len;
    logic             o_abort;

    modport master (
        output i_valid, i_data, i_sop, i_eop,
        input  o_ready, o_done, o_pass, o_err_len, o_residue, o_len, o_abort
    );

    modport slave (
        input  i_valid, i_data, i_sop, i_eop,
        output o_ready, o_done, o_pass, o_err_len, o_residue, o_len, o_abort
    );
endinterface

// File: rtl/crc8_checker_core.sv
// Bit-serial CRC-8 engine: loads a byte, then shifts it MSB first through the
// CRC register over exactly eight cycles.
module crc8_serial_core
    import crc_pkg::*;
#(
    parameter logic [7:0] POLY = CRC8_POLY,
    parameter logic [7:0] INIT = CRC8_INIT
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       load_i,
    input  logic       init_i,
    input  logic [7:0] data_i,
    output logic       done_o,
    output logic [7:0] crcNext_o
);

    logic [7:0] crc_q, crc_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] cnt_q, cnt_d;
    logic       busy_q, busy_d;

    assign crcNext_o = crc8_bit(crc_q, shift_q[7], POLY);
    assign done_o    = busy_q && (cnt_q == 3'd7);

    always_comb begin
        crc_d   = crc_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        if (load_i) begin
            shift_d = data_i;
            cnt_d   = 3'd0;
            busy_d  = 1'b1;
            if (init_i) begin
                crc_d = INIT;
            end
        end else if (busy_q) begin
            crc_d   = crcNext_o;
            shift_d = {shift_q[6:0], 1'b0};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            crc_q   <= INIT;
            shift_q <= 8'h00;
            cnt_q   <= 3'd0;
            busy_q  <= 1'b0;
        end else begin
            crc_q   <= crc_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

endmodule

// File: rtl/crc8_checker.sv
// Receive-side CRC-8 frame checker: feeds every byte, CRC byte included, through
// the serial core and reports pass/fail from the zero-residue rule.
module crc8_checker
    import crc_pkg::*;
#(
    parameter logic [7:0] POLY  = CRC8_POLY,
    parameter logic [7:0] INIT  = CRC8_INIT,
    parameter int         LEN_W = 16
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    crc8_checker_if.slave  bus
);

    state_e           state_q, state_d;
    logic             inFrame_q, inFrame_d;
    logic             eop_q, eop_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             abort_q, abort_d;

    logic             pass_q, errLen_q;
    logic [7:0]       residue_q;
    logic [LEN_W-1:0] lenOut_q;

    logic             coreLoad, coreInit, coreDone, resLoad;
    logic [7:0]       coreCrcNext;

    crc8_serial_core #(
        .POLY (POLY),
        .INIT (INIT)
    ) u_core (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .load_i    (coreLoad),
        .init_i    (coreInit),
        .data_i    (bus.i_data),
        .done_o    (coreDone),
        .crcNext_o (coreCrcNext)
    );

    // A sop that lands while a frame is still open restarts framing and flags the loss.
    always_comb begin
        state_d   = state_q;
        inFrame_d = inFrame_q;
        eop_d     = eop_q;
        len_d     = len_q;
        abort_d   = 1'b0;
        coreLoad  = 1'b0;
        coreInit  = 1'b0;
        resLoad   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.i_valid && bus.i_sop) begin
                    coreLoad  = 1'b1;
                    coreInit  = 1'b1;
                    len_d     = LEN_W'(1);
                    inFrame_d = 1'b1;
                    eop_d     = bus.i_eop;
                    abort_d   = inFrame_q;
                    state_d   = SHIFT;
                end else if (bus.i_valid && inFrame_q) begin
                    coreLoad = 1'b1;
                    len_d    = (len_q == {LEN_W{1'b1}}) ? len_q : len_q + LEN_W'(1);
                    eop_d    = bus.i_eop;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (coreDone) begin
                    resLoad = eop_q;
                    state_d = eop_q ? DONE : IDLE;
                end
            end
            DONE: begin
                inFrame_d = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            inFrame_q <= 1'b0;
            eop_q     <= 1'b0;
            len_q     <= '0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            inFrame_q <= inFrame_d;
            eop_q     <= eop_d;
            len_q     <= len_d;
            abort_q   <= abort_d;
        end
    end

    // Results are captured from the final shift so they are already stable during DONE.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pass_q    <= 1'b0;
            errLen_q  <= 1'b0;
            residue_q <= 8'h00;
            lenOut_q  <= '0;
        end else if (resLoad) begin
            pass_q    <= (coreCrcNext == 8'h00) && (len_q >= LEN_W'(2));
            errLen_q  <= (len_q < LEN_W'(2));
            residue_q <= coreCrcNext;
            lenOut_q  <= len_q;
        end
    end

    assign bus.o_ready   = (state_q == IDLE);
    assign bus.o_done    = (state_q == DONE);
    assign bus.o_pass    = pass_q;
    assign bus.o_err_len = errLen_q;
    assign bus.o_residue = residue_q;
    assign bus.o_len     = lenOut_q;
    assign bus.o_abort   = abort_q;

endmodule

// File: tb/tb_crc8_checker.sv
// Self-checking bench for crc8_checker: fixed vectors, handshake timing, abort
// and reset corner cases, then random frames against a byte-wise CRC model.
module tb_crc8_checker;

    localparam int LEN_W = 16;

    logic clk = 1'b0;
    logic rstN;

    always #5 clk = ~clk;

    crc8_checker_if #(.LEN_W(LEN_W)) bus ();

    crc8_checker #(
        .POLY  (8'h07),
        .INIT  (8'h00),
        .LEN_W (LEN_W)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rstN),
        .bus     (bus.slave)
    );

    int checks     = 0;
    int errors     = 0;
    int doneCount  = 0;
    int abortCount = 0;

    // Pulse counters sampled mid-cycle; the main thread reads them just after posedges.
    always @(negedge clk) begin
        if (bus.o_done === 1'b1) doneCount++;
        if (bus.o_abort === 1'b1) abortCount++;
    end

    typedef struct packed {
        logic [3:0]  n;
        logic [95:0] data;
        logic        expPass;
        logic        expErr;
        logic [7:0]  expRes;
        logic [15:0] expLen;
    } vec_t;

    vec_t vecs[5];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Byte-at-a-time CRC-8 (poly 0x07, init 0x00), the textbook table-free form.
    function automatic logic [7:0] refCrc(input logic [7:0] msg[$]);
        logic [7:0] crc;
        crc = 8'h00;
        foreach (msg[i]) begin
            crc = crc ^ msg[i];
            for (int k = 0; k < 8; k++) begin
                crc = (crc & 8'h80) != 8'h00 ? ((crc << 1) ^ 8'h07) : (crc << 1);
            end
        end
        return crc;
    endfunction

    task automatic applyStimulus(input logic [7:0] d, input logic s, input logic e);
        int waitCycles;
        waitCycles = 0;
        @(negedge clk);
        bus.i_valid = 1'b1;
        bus.i_data  = d;
        bus.i_sop   = s;
        bus.i_eop   = e;
        while (bus.o_ready !== 1'b1 && waitCycles < 40) begin
            @(negedge clk);
            waitCycles++;
        end
        if (bus.o_ready !== 1'b1) begin
            checkOutput("ready_timeout", 32'(bus.o_ready), 32'd1);
        end
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        bus.i_sop   = 1'b0;
        bus.i_eop   = 1'b0;
    endtask

    task automatic waitDone(output logic got, output logic pass, output logic err,
                            output logic [7:0] res, output logic [15:0] len);
        got  = 1'b0;
        pass = 1'b0;
        err  = 1'b0;
        res  = 8'h00;
        len  = 16'h0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.o_done === 1'b1) begin
                got  = 1'b1;
                pass = bus.o_pass;
                err  = bus.o_err_len;
                res  = bus.o_residue;
                len  = bus.o_len;
                break;
            end
        end
        checkOutput("done_seen", 32'(got), 32'd1);
    endtask

    task automatic runFrame(input logic [7:0] msg[$], input int gapMax,
                            output logic got, output logic pass, output logic err,
                            output logic [7:0] res, output logic [15:0] len);
        for (int i = 0; i < msg.size(); i++) begin
            if (gapMax > 0) repeat ($urandom_range(gapMax, 0)) @(negedge clk);
            applyStimulus(msg[i], i == 0, i == msg.size() - 1);
        end
        waitDone(got, pass, err, res, len);
    endtask

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0]  msg[$];
        logic        got, pass, err;
        logic [7:0]  res, c;
        logic [15:0] len;
        int          lowCycles, d0, a0, n;

        bus.i_valid = 1'b0;
        bus.i_data  = 8'h00;
        bus.i_sop   = 1'b0;
        bus.i_eop   = 1'b0;
        rstN        = 1'b0;
        repeat (3) @(negedge clk);

        checkOutput("rst_ready",   32'(bus.o_ready),   32'd1);
        checkOutput("rst_done",    32'(bus.o_done),    32'd0);
        checkOutput("rst_pass",    32'(bus.o_pass),    32'd0);
        checkOutput("rst_err_len", 32'(bus.o_err_len), 32'd0);
        checkOutput("rst_residue", 32'(bus.o_residue), 32'd0);
        checkOutput("rst_len",     32'(bus.o_len),     32'd0);
        checkOutput("rst_abort",   32'(bus.o_abort),   32'd0);
        rstN = 1'b1;
        repeat (2) @(negedge clk);

        vecs[0] = '{n: 4'd10, data: {16'h0, 8'hF4, 8'h39, 8'h38, 8'h37, 8'h36, 8'h35,
                    8'h34, 8'h33, 8'h32, 8'h31}, expPass: 1'b1, expErr: 1'b0,
                    expRes: 8'h00, expLen: 16'd10};
        vecs[1] = '{n: 4'd2, data: {80'h0, 8'h07, 8'h01}, expPass: 1'b1, expErr: 1'b0,
                    expRes: 8'h00, expLen: 16'd2};
        vecs[2] = '{n: 4'd2, data: {80'h0, 8'h08, 8'h01}, expPass: 1'b0, expErr: 1'b0,
                    expRes: 8'h2D, expLen: 16'd2};
        vecs[3] = '{n: 4'd1, data: {88'h0, 8'h00}, expPass: 1'b0, expErr: 1'b1,
                    expRes: 8'h00, expLen: 16'd1};
        vecs[4] = '{n: 4'd2, data: {80'h0, 8'h00, 8'h00}, expPass: 1'b1, expErr: 1'b0,
                    expRes: 8'h00, expLen: 16'd2};

        for (int v = 0; v < 5; v++) begin
            msg.delete();
            for (int i = 0; i < int'(vecs[v].n); i++) msg.push_back(vecs[v].data[8*i +: 8]);
            runFrame(msg, 0, got, pass, err, res, len);
            checkOutput($sformatf("vec%0d_pass", v),    32'(pass), 32'(vecs[v].expPass));
            checkOutput($sformatf("vec%0d_err_len", v), 32'(err),  32'(vecs[v].expErr));
            checkOutput($sformatf("vec%0d_residue", v), 32'(res),  32'(vecs[v].expRes));
            checkOutput($sformatf("vec%0d_len", v),     32'(len),  32'(vecs[v].expLen));
        end

        // Back-to-back: i_valid held high for a whole 3-byte frame.
        msg.delete();
        msg.push_back(8'h12);
        msg.push_back(8'h34);
        c = refCrc(msg);
        msg.push_back(c);
        @(negedge clk);
        bus.i_valid = 1'b1;
        bus.i_data  = msg[0];
        bus.i_sop   = 1'b1;
        bus.i_eop   = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("cont_ready_b%0d", k), 32'(bus.o_ready), 32'd1);
            @(posedge clk);
            lowCycles = 0;
            for (int j = 0; j < 8; j++) begin
                @(negedge clk);
                if (bus.o_ready === 1'b0) lowCycles++;
                if (j == 0 && k < 2) begin
                    bus.i_data = msg[k+1];
                    bus.i_sop  = 1'b0;
                    bus.i_eop  = (k == 1);
                end
            end
            checkOutput($sformatf("cont_low_b%0d", k), 32'(lowCycles), 32'd8);
            @(negedge clk);
            if (k == 2) begin
                checkOutput("cont_done",  32'(bus.o_done),  32'd1);
                checkOutput("cont_ready", 32'(bus.o_ready), 32'd0);
                checkOutput("cont_pass",  32'(bus.o_pass),  32'd1);
                checkOutput("cont_len",   32'(bus.o_len),   32'd3);
                bus.i_valid = 1'b0;
                bus.i_eop   = 1'b0;
            end
        end
        repeat (3) @(negedge clk);

        // Abort: open frame {AA, BB} interrupted by a new sop.
        @(posedge clk);
        a0 = abortCount;
        d0 = doneCount;
        applyStimulus(8'hAA, 1'b1, 1'b0);
        applyStimulus(8'hBB, 1'b0, 1'b0);
        applyStimulus(8'h01, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("abort_pulse", 32'(bus.o_abort), 32'd1);
        @(negedge clk);
        checkOutput("abort_width", 32'(bus.o_abort), 32'd0);
        applyStimulus(8'h07, 1'b0, 1'b1);
        waitDone(got, pass, err, res, len);
        checkOutput("abort_pass", 32'(pass), 32'd1);
        checkOutput("abort_len",  32'(len),  32'd2);
        repeat (3) @(negedge clk);
        @(posedge clk);
        checkOutput("abort_count", 32'(abortCount - a0), 32'd1);
        checkOutput("abort_dones", 32'(doneCount - d0),  32'd1);

        // Reset four cycles into the eop byte's shifting.
        applyStimulus(8'h01, 1'b1, 1'b0);
        applyStimulus(8'h07, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        rstN = 1'b0;
        #1;
        checkOutput("midrst_ready", 32'(bus.o_ready), 32'd1);
        checkOutput("midrst_done",  32'(bus.o_done),  32'd0);
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        d0 = doneCount;
        repeat (15) @(negedge clk);
        @(posedge clk);
        checkOutput("midrst_no_done", 32'(doneCount - d0), 32'd0);
        checkOutput("midrst_idle",    32'(bus.o_ready),    32'd1);

        // Stray byte without sop while idle must be dropped.
        applyStimulus(8'h55, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("stray_ready", 32'(bus.o_ready), 32'd1);
        repeat (12) @(negedge clk);
        @(posedge clk);
        checkOutput("stray_no_done", 32'(doneCount - d0), 32'd0);

        msg.delete();
        msg.push_back(8'h01);
        msg.push_back(8'h07);
        runFrame(msg, 0, got, pass, err, res, len);
        checkOutput("post_rst_pass", 32'(pass), 32'd1);
        checkOutput("post_rst_len",  32'(len),  32'd2);

        // Random frames, half of them carrying a correct trailing CRC.
        for (int f = 0; f < 40; f++) begin
            msg.delete();
            n = int'($urandom_range(8, 1));
            for (int i = 0; i < n; i++) msg.push_back(8'($urandom_range(255, 0)));
            if (n >= 2 && $urandom_range(1, 0) == 1) begin
                msg.pop_back();
                c = refCrc(msg);
                msg.push_back(c);
            end
            c = refCrc(msg);
            runFrame(msg, 2, got, pass, err, res, len);
            checkOutput($sformatf("rnd%0d_pass", f),    32'(pass), 32'((c == 8'h00) && (n >= 2)));
            checkOutput($sformatf("rnd%0d_err_len", f), 32'(err),  32'(n < 2));
            checkOutput($sformatf("rnd%0d_residue", f), 32'(res),  32'(c));
            checkOutput($sformatf("rnd%0d_len", f),     32'(len),  32'(n));
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/crc8_checker.md
Name: crc8_checker

Overview:
- Receive-side counterpart of the bit-serial CRC-8 generator.
- Accepts a byte-framed stream (sop/eop) whose final byte is the transmitted CRC-8. It runs every byte, including the CRC byte, through a bit-serial CRC engine, MSB first.
- Reports pass/fail per frame from the zero-residue rule.
- Sits between the UART byte receiver and the frame consumer.

Parameters:
- POLY, 8'h07, generator polynomial (x^8+x^2+x+1, implicit x^8).
- INIT, 8'h00, CRC register value at start of frame.
- LEN_W, 16, width of the frame byte counter.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  byte present on i_data.
- i_data  in  8  received byte.
- i_sop  in  1  first byte of frame; qualified by i_valid.
- i_eop  in  1  last byte of frame (the CRC byte); qualified by i_valid.
- o_ready  out  1  checker can take a byte this cycle.
- o_done  out  1  one-cycle pulse: frame result valid.
- o_pass  out  1  frame CRC correct; valid with o_done.
- o_err_len  out  1  frame shorter than 2 bytes; valid with o_done.
- o_residue  out  8  final CRC register; 0 on pass; valid with o_done.
- o_len  out  LEN_W  bytes in frame, CRC byte included; valid with o_done.
- o_abort  out  1  one-cycle pulse: open frame discarded by a new sop.

Behaviour:
- Reset (async assert, sync release) values:
  - All outputs 0 except o_ready = 1.
  - State IDLE, CRC register = INIT, bit counter 0, length 0, in_frame 0.
- Handshake:
  - A byte is accepted on a rising edge where i_valid && o_ready.
  - i_data, i_sop and i_eop are sampled only then.
  - o_ready depends only on state and does not depend on i_valid.
- States:
  - IDLE: o_ready = 1.
    - Accept with i_sop: CRC reg = INIT, length = 1, in_frame = 1, latch byte and eop flag, go to SHIFT.
    - Accept without i_sop and in_frame = 1: length + 1, go to SHIFT.
    - Accept without i_sop and in_frame = 0: byte dropped, stay in IDLE, no pulse.
  - SHIFT: o_ready = 0, for exactly 8 cycles, bit 7 down to bit 0.
    - Per cycle: fb = crc[7] ^ bit; crc = {crc[6:0],1'b0} ^ (fb ? POLY : 8'h00).
    - After the 8th cycle: go to DONE if the latched eop = 1, else go to IDLE.
  - DONE: one cycle, o_ready = 0.
    - o_done = 1; o_pass = (crc == 0) && (len >= 2); o_err_len = (len < 2).
    - o_residue = crc; o_len = length.
    - Then clear in_frame and go to IDLE.
- Timing: byte accepted at edge E0 → o_ready low E0..E8 → o_ready high again after E8 (non-eop byte). Peak rate is 1 byte per 9 cycles.
- eop latency: accepted at E0 → o_done high in the cycle after E8 → IDLE after E9.
- Result outputs: o_pass, o_err_len, o_residue and o_len are registered, hold their value until the next o_done, and are meaningful only while o_done = 1.
- sop while in_frame = 1 (accepted in IDLE): o_abort pulses for 1 cycle on the acceptance edge and the new frame starts normally. The old frame produces no o_done.
- Same byte carrying sop and eop: processed, then o_done with o_err_len = 1 and o_pass = 0.
- Length counter saturates at all-ones; no wrap.
- Deasserting i_rst_n mid-SHIFT or in DONE discards the frame immediately; no o_done pulse is emitted.

Decomposition:
- Shared package crc_pkg holds:
  - CRC8_POLY = 8'h07 and CRC8_INIT = 8'h00, shared with the generator.
  - The state enum {IDLE, SHIFT, DONE}.
  - The function crc8_bit(crc, bit) returning the next CRC.
- One natural sub-module: crc8_serial_core. It holds the 8-bit CRC register, the load/init and 3-bit shift counter, and a done flag. The generator side can reuse it.
- Framing, length and result logic stay in crc8_checker.

Test Plan:
- Frame 0x31..0x39 ("123456789") + 0xF4 → o_done once, o_pass = 1, o_residue = 0x00, o_len = 10.
- Frame {0x01, 0x07} → pass, o_len = 2. Frame {0x01, 0x08} → o_pass = 0, o_residue = 0x2D.
- Single byte 0x00 with sop = eop = 1 → o_done, o_err_len = 1, o_pass = 0, o_len = 1.
- Hold i_valid high continuously over a 3-byte frame → o_ready low exactly 8 cycles after each accept. No byte lost or duplicated. o_done 9 cycles after the eop accept.
- Frame {0xAA, 0xBB}, then sop 0x01 before eop, then 0x07 with eop → o_abort pulse, one o_done with pass, o_len = 2.
- Reset asserted 4 cycles into the eop byte's SHIFT → no o_done, o_ready = 1. Next valid frame passes. A byte without sop while idle is ignored.
